ad9783_spi_rdback: RTL

- 3-wire SPI read master for the AD9783 DAC. It issues register-read transactions and returns the byte(s) the DAC drives back on the shared SDIO line.
- It is the read-side counterpart of the DAC configuration/write path. It lets firmware and the built-in test logic confirm that full-scale-current and mode registers hold what was written.
- Sits in the clk_5m_bufg domain. Its pins are muxed onto iob_dac1_spi_csb/clk/sda by the top level.

---
 rtl/ad9783_spi_pkg.sv | 46 ++++
 rtl/ad9783_spi_rdback_if.sv | 30 +++
 rtl/spi_sclk_gen.sv | 39 +++
 rtl/ad9783_spi_rdback.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/ad9783_spi_pkg.sv
// Shared AD9783 SPI definitions: read-master FSM states, instruction byte layout
// and register map used by both the read and write paths.
package ad9783_spi_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned LEN_W  = 2;
  localparam int unsigned DATA_W = 32;

  localparam int unsigned INSTR_RW_BIT   = 7;
  localparam int unsigned INSTR_N_MSB    = 6;
  localparam int unsigned INSTR_N_LSB    = 5;
  localparam int unsigned INSTR_ADDR_MSB = 4;
  localparam int unsigned INSTR_ADDR_LSB = 0;

  localparam logic [ADDR_W-1:0] REG_SPI_CTRL     = 5'h00;
  localparam logic [ADDR_W-1:0] REG_DATA_CTRL    = 5'h02;
  localparam logic [ADDR_W-1:0] REG_POWER_DOWN   = 5'h03;
  localparam logic [ADDR_W-1:0] REG_SETUP_HOLD   = 5'h04;
  localparam logic [ADDR_W-1:0] REG_TIMING_ADJ   = 5'h05;
  localparam logic [ADDR_W-1:0] REG_SEEK         = 5'h06;
  localparam logic [ADDR_W-1:0] REG_MIX_MODE     = 5'h0A;
  localparam logic [ADDR_W-1:0] REG_DAC1_FSC     = 5'h0B;
  localparam logic [ADDR_W-1:0] REG_DAC1_FSC_MSB = 5'h0C;
  localparam logic [ADDR_W-1:0] REG_DAC2_FSC     = 5'h0F;
  localparam logic [ADDR_W-1:0] REG_DAC2_FSC_MSB = 5'h10;

  typedef enum logic [2:0] {
    ST_IDLE, ST_SETUP, ST_INSTR, ST_DATA, ST_HOLD, ST_GAP
  } rd_state_e;

  typedef struct packed {
    logic [LEN_W-1:0]  len;
    logic [ADDR_W-1:0] addr;
  } rd_cmd_t;

  // Read instruction: R/W=1, byte count minus one, register address.
  function automatic logic [7:0] instr_byte(input rd_cmd_t cmd);
    logic [7:0] b;
    b = '0;
    b[INSTR_RW_BIT]                   = 1'b1;
    b[INSTR_N_MSB:INSTR_N_LSB]        = cmd.len;
    b[INSTR_ADDR_MSB:INSTR_ADDR_LSB]  = cmd.addr;
    return b;
  endfunction

endpackage

// File: rtl/ad9783_spi_rdback_if.sv
// Request/response handshake and 3-wire SPI pins of the AD9783 read master.
interface ad9783_spi_rdback_if;
  import ad9783_spi_pkg::*;

  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [LEN_W-1:0]  rd_len;
  logic              rd_abort;
  logic              rd_busy;
  logic              rd_done;
  logic              rd_aborted;
  logic [DATA_W-1:0] rd_data;
  logic              spi_csb;
  logic              spi_clk;
  logic              spi_sda_o;
  logic              spi_sda_oe;
  logic              spi_sda_i;

  modport master (
    output rd_req, rd_addr, rd_len, rd_abort, spi_sda_i,
    input  rd_busy, rd_done, rd_aborted, rd_data,
    input  spi_csb, spi_clk, spi_sda_o, spi_sda_oe
  );

  modport slave (
    input  rd_req, rd_addr, rd_len, rd_abort, spi_sda_i,
    output rd_busy, rd_done, rd_aborted, rd_data,
    output spi_csb, spi_clk, spi_sda_o, spi_sda_oe
  );
endinterface

// File: rtl/spi_sclk_gen.sv
// SPI clock generator: while run is high, spi clock toggles every SCLK_HALF
// clocks starting low; rise_c/fall_c flag the edge that changes it.
module spi_sclk_gen #(
  parameter int unsigned SCLK_HALF = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic sclk,
  output logic rise_c,
  output logic fall_c
);

  localparam int unsigned CNT_W = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCLK_HALF - 1);

  logic [CNT_W-1:0] cnt;
  logic             half_end_c;

  assign half_end_c = run && (cnt == CNT_LAST);
  assign rise_c     = half_end_c && !sclk;
  assign fall_c     = half_end_c && sclk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (!run) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (half_end_c) begin
      cnt  <= '0;
      sclk <= ~sclk;
    end else begin
      cnt  <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/ad9783_spi_rdback.sv
// AD9783 3-wire SPI read master: sends a read instruction, turns SDIO around
// and collects 1..4 bytes, first byte most significant.
module ad9783_spi_rdback
  import ad9783_spi_pkg::*;
#(
  parameter int unsigned SCLK_HALF = 2,
  parameter int unsigned GAP_CYC   = 4
) (
  input  logic                clk_5m_bufg,
  input  logic                rst_glb,
  ad9783_spi_rdback_if.slave  bus
);

  localparam int unsigned CNT_MAX = (SCLK_HALF > GAP_CYC) ? SCLK_HALF : GAP_CYC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SCLK_HALF);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(SCLK_HALF - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYC - 1);

  rd_state_e         state;
  logic [LEN_W-1:0]  len_q;
  logic [CNT_W-1:0]  cnt;
  logic [4:0]        bit_cnt;
  logic [7:0]        tx_sh;
  logic [DATA_W-1:0] rx_sh;
  logic [DATA_W-1:0] data;
  logic              csb, sda_o, sda_oe, busy, done, aborted;
  logic              sclk;
  logic              run_c, rise_c, fall_c, active_c, last_data_c;
  rd_cmd_t           req_cmd_c;

  assign req_cmd_c   = '{len: bus.rd_len, addr: bus.rd_addr};
  assign active_c    = state inside {ST_SETUP, ST_INSTR, ST_DATA, ST_HOLD};
  // Gating with abort parks spi_clk low on the same edge that raises CSB.
  assign run_c       = ((state == ST_INSTR) || (state == ST_DATA)) && !bus.rd_abort;
  assign last_data_c = (bit_cnt == {len_q, 3'b111});

  spi_sclk_gen #(.SCLK_HALF(SCLK_HALF)) u_sclk_gen (
    .clk    (clk_5m_bufg),
    .rst_n  (rst_glb),
    .run    (run_c),
    .sclk   (sclk),
    .rise_c (rise_c),
    .fall_c (fall_c)
  );

  always_ff @(posedge clk_5m_bufg or negedge rst_glb) begin
    if (!rst_glb) begin
      state   <= ST_IDLE;
      len_q   <= '0;
      cnt     <= '0;
      bit_cnt <= '0;
      tx_sh   <= '0;
      rx_sh   <= '0;
      data    <= '0;
      csb     <= 1'b1;
      sda_o   <= 1'b0;
      sda_oe  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      aborted <= 1'b0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      if (active_c && bus.rd_abort) begin
        state   <= ST_GAP;
        cnt     <= '0;
        csb     <= 1'b1;
        sda_oe  <= 1'b0;
        sda_o   <= 1'b0;
        aborted <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: if (bus.rd_req) begin
            len_q <= bus.rd_len;
            tx_sh <= instr_byte(req_cmd_c);
            rx_sh <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ST_SETUP;
          end
          // First SETUP clock drops CSB and presents the instruction MSB.
          ST_SETUP: begin
            if (cnt == '0) begin
              csb    <= 1'b0;
              sda_oe <= 1'b1;
              sda_o  <= tx_sh[7];
              tx_sh  <= {tx_sh[6:0], 1'b0};
            end
            if (cnt == SETUP_LAST) begin
              state   <= ST_INSTR;
              bit_cnt <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          ST_INSTR: if (fall_c) begin
            if (bit_cnt == 5'd7) begin
              state   <= ST_DATA;
              bit_cnt <= '0;
              sda_oe  <= 1'b0;
              sda_o   <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
              sda_o   <= tx_sh[7];
              tx_sh   <= {tx_sh[6:0], 1'b0};
            end
          end
          ST_DATA: begin
            if (rise_c) rx_sh <= {rx_sh[DATA_W-2:0], bus.spi_sda_i};
            if (fall_c) begin
              if (last_data_c) begin
                state <= ST_HOLD;
                cnt   <= '0;
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          end
          ST_HOLD: begin
            if (cnt == HOLD_LAST) begin
              state <= ST_GAP;
              cnt   <= '0;
              csb   <= 1'b1;
              done  <= 1'b1;
              data  <= rx_sh;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          ST_GAP: begin
            if (cnt == GAP_LAST) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.spi_csb    = csb;
  assign bus.spi_clk    = sclk;
  assign bus.spi_sda_o  = sda_o;
  assign bus.spi_sda_oe = sda_oe;
  assign bus.rd_busy    = busy;
  assign bus.rd_done    = done;
  assign bus.rd_aborted = aborted;
  assign bus.rd_data    = data;

endmodule
